// File: rtl/ysyx_23060286_lsu.sv
// ============================================================================
// Module   : ysyx_23060286_lsu
// Brief    : Multi-cycle load/store unit, one aligned 32-bit bus op in flight
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060286_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_f3,
  input  logic        ex_load,
  input  logic        ex_store,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_result,
  output logic        wb_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic        r_store;
  logic [31:0] r_result;
  logic        r_err;

  logic        w_f3_ok_ld;
  logic        w_f3_ok_st;
  logic        w_misal;
  logic        w_err;
  logic [1:0]  w_off;
  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_load;

  // Legality is decided at accept time so illegal ops never reach the bus
  always_comb begin
    w_f3_ok_ld = (ex_f3 == 3'b000) | (ex_f3 == 3'b001) | (ex_f3 == 3'b010) |
                 (ex_f3 == 3'b100) | (ex_f3 == 3'b101);
    w_f3_ok_st = ~ex_f3[2] & (ex_f3[1:0] != 2'b11);
    w_misal    = ((ex_f3[1:0] == 2'b01) & ex_addr[0]) |
                 ((ex_f3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00));
    w_err      = (ex_load & ex_store) |
                 (ex_load & ~w_f3_ok_ld) |
                 (ex_store & ~w_f3_ok_st) |
                 ((ex_load | ex_store) & w_misal);
  end

  assign w_off   = r_addr[1:0];
  assign w_shamt = {w_off, 3'b000};

  assign ex_ready      = (r_state == S_IDLE) & ~rst;
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_addr      = {r_addr[31:2], 2'b00};
  assign mem_wen       = r_store;
  assign mem_wdata     = r_wdata << w_shamt;
  assign wb_valid      = (r_state == S_DONE);
  assign wb_result     = r_result;
  assign wb_err        = r_err;

  always_comb begin
    mem_wstrb = 4'b0000;
    if (r_store) begin
      case (r_f3[1:0])
        2'b00:   mem_wstrb = 4'b0001 << w_off;
        2'b01:   mem_wstrb = 4'b0011 << w_off;
        default: mem_wstrb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    w_shifted = mem_rdata >> w_shamt;
    case (r_f3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load = {24'd0, w_shifted[7:0]};
      3'b101:  w_load = {16'd0, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_f3     <= 3'd0;
      r_store  <= 1'b0;
      r_result <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ex_valid) begin
            r_addr  <= ex_addr;
            r_wdata <= ex_wdata;
            r_f3    <= ex_f3;
            r_store <= ex_store;
            if (!ex_load && !ex_store) begin
              r_result <= ex_addr;
              r_err    <= 1'b0;
              r_state  <= S_DONE;
            end else if (w_err) begin
              r_result <= 32'd0;
              r_err    <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // A response coinciding with acceptance belongs to nothing yet
          if (mem_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            r_result <= r_store ? 32'd0 : w_load;
            r_err    <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (wb_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060286_lsu.sv
// ============================================================================
// Module   : tb_ysyx_23060286_lsu
// Brief    : Self-checking bench for the LSU with a behavioural reference model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060286_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_load, ex_store;
  logic [31:0] ex_addr, ex_wdata;
  logic [2:0]  ex_f3;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_ready, wb_err;
  logic [31:0] wb_result;

  int checks = 0;
  int errors = 0;

  // Observations gathered by the bus/write-back driver
  logic [31:0] obs_result, obs_addr, obs_wdata;
  logic [3:0]  obs_wstrb;
  logic        obs_err, obs_wen;
  int          obs_lat, obs_nreq;
  bit          obs_saw_req, obs_req_stable, obs_wb_stable, obs_ready_early;
  bit          obs_timeout, obs_ready_at_accept;

  always #5 clk = ~clk;

  ysyx_23060286_lsu dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_f3(ex_f3), .ex_load(ex_load), .ex_store(ex_store),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_result(wb_result), .wb_err(wb_err)
  );

  // Reference: decide access size, legality, byte lanes and extension arithmetically
  function automatic void ref_op(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, output bit e_err, output bit e_bus,
                                 output logic [31:0] e_res, output logic [31:0] e_wdata,
                                 output logic [3:0] e_wstrb);
    int size, o;
    longint v;
    o = int'(addr % 4);
    e_err = 0; e_bus = 0; e_res = 0; e_wdata = 0; e_wstrb = 0;
    if (!ld && !st) begin e_res = addr; return; end
    if (ld && st) begin e_err = 1; return; end
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (st && f3 > 3'd2) size = 0;
    if (size == 0 || (o % size) != 0) begin e_err = 1; return; end
    e_bus = 1;
    if (st) begin
      e_wdata = 32'(longint'(wdata) << (8 * o));
      e_wstrb = 4'(((1 << size) - 1) << o);
    end else begin
      v = (longint'(rdata) >> (8 * o)) % (longint'(1) << (8 * size));
      if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      e_res = 32'(v);
    end
  endfunction

  // Drives one instruction through accept, bus and write-back, recording what it sees
  task automatic do_txn(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int req_lat, input int resp_lat,
                        input int wb_lat, input bit junk);
    int cyc, rqw, rsw, wbw;
    bit in_wait, done;
    obs_result = 0; obs_err = 0; obs_addr = 0; obs_wdata = 0; obs_wstrb = 0; obs_wen = 0;
    obs_lat = -1; obs_nreq = 0; obs_saw_req = 0; obs_req_stable = 1; obs_wb_stable = 1;
    obs_ready_early = 0;
    ex_valid = 1; ex_load = ld; ex_store = st; ex_f3 = f3; ex_addr = addr; ex_wdata = wdata;
    obs_ready_at_accept = ex_ready;
    @(posedge clk); #1;
    ex_valid = 0; ex_addr = $urandom; ex_wdata = $urandom; ex_f3 = 3'($urandom);
    ex_load = 1'($urandom); ex_store = 1'($urandom);
    cyc = 1; rqw = 0; rsw = 0; wbw = 0; in_wait = 0; done = 0;
    while (!done && cyc <= 100) begin
      mem_req_ready = 0; mem_resp_valid = 0; wb_ready = 0; mem_rdata = $urandom;
      if (ex_ready) obs_ready_early = 1;
      if (in_wait) begin
        if (rsw >= resp_lat) begin mem_resp_valid = 1; mem_rdata = rdata; in_wait = 0; end
        rsw++;
      end
      if (mem_req_valid) begin
        if (!obs_saw_req) begin
          obs_saw_req = 1; obs_addr = mem_addr; obs_wen = mem_wen;
          obs_wstrb = mem_wstrb; obs_wdata = mem_wdata;
        end else if (mem_addr !== obs_addr || mem_wstrb !== obs_wstrb ||
                     mem_wdata !== obs_wdata || mem_wen !== obs_wen) begin
          obs_req_stable = 0;
        end
        if (rqw >= req_lat) begin
          mem_req_ready = 1; obs_nreq++; in_wait = 1; rsw = 0;
          if (junk) mem_resp_valid = 1;
        end
        rqw++;
      end
      if (wb_valid) begin
        if (obs_lat < 0) begin
          obs_lat = cyc; obs_result = wb_result; obs_err = wb_err;
        end else if (wb_result !== obs_result || wb_err !== obs_err) begin
          obs_wb_stable = 0;
        end
        if (wbw >= wb_lat) begin wb_ready = 1; done = 1; end
        wbw++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_req_ready = 0; mem_resp_valid = 0; wb_ready = 0;
    obs_timeout = !done;
    if (obs_timeout) begin
      errors++;
      $display("FAIL txn_timeout addr=%h got no wb handshake within 100 cycles", addr);
    end
  endtask

  task automatic test_reset();
    rst = 1; ex_valid = 0; ex_load = 0; ex_store = 0; ex_f3 = 0; ex_addr = 0; ex_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; wb_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_req_valid, wb_valid, wb_err, ex_ready} !== 4'b0000 || wb_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b wbv=%b err=%b rdy=%b res=%h exp all 0",
               mem_req_valid, wb_valid, wb_err, ex_ready, wb_result);
    end
    rst = 0; #1;
    checks++;
    if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ex_ready); end
    ex_valid = 1; ex_load = 1; ex_f3 = 3'd2; ex_addr = 32'h100;
    @(posedge clk); #1;
    ex_valid = 0; ex_load = 0;
    checks++;
    if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_inflight_req got %b exp 1", mem_req_valid); end
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if (mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL reset_midop got req=%b wbv=%b exp 0 0", mem_req_valid, wb_valid);
    end
    @(posedge clk); #1;
    rst = 0; #1;
    checks++;
    if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", ex_ready); end
    mem_resp_valid = 1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_resp_valid = 0;
    checks++;
    if (wb_valid !== 1'b0 || mem_req_valid !== 1'b0 || ex_ready !== 1'b1) begin
      errors++; $display("FAIL late_resp got wbv=%b req=%b rdy=%b exp 0 0 1", wb_valid, mem_req_valid, ex_ready);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] addrs [3] = '{32'h80000003, 32'h80000003, 32'h80000002};
    logic [2:0]  f3s   [3] = '{3'd4, 3'd0, 3'd5};
    logic [31:0] exps  [3] = '{32'h00000080, 32'hFFFFFF80, 32'h000080FF};
    for (int i = 0; i < 3; i++) begin
      do_txn(1'b1, 1'b0, f3s[i], addrs[i], 32'h0, 32'h80FF1234, 0, 0, 0, 1'b0);
      checks++;
      if (obs_addr !== 32'h80000000 || obs_wstrb !== 4'b0000 || obs_wen !== 1'b0) begin
        errors++; $display("FAIL load_bus[%0d] got addr=%h strb=%b wen=%b exp 80000000 0000 0",
                           i, obs_addr, obs_wstrb, obs_wen);
      end
      checks++;
      if (obs_result !== exps[i] || obs_err !== 1'b0) begin
        errors++; $display("FAIL load_ext[%0d] got %h err=%b exp %h err=0", i, obs_result, obs_err, exps[i]);
      end
      checks++;
      if (obs_lat !== 3) begin errors++; $display("FAIL load_latency[%0d] got %0d exp 3", i, obs_lat); end
    end
  endtask

  task automatic test_store_sb();
    do_txn(1'b0, 1'b1, 3'd0, 32'h10000002, 32'h000000AB, 32'h0, 0, 0, 0, 1'b0);
    checks++;
    if (obs_wen !== 1'b1 || obs_wstrb !== 4'b0100 || obs_wdata !== 32'h00AB0000 || obs_addr !== 32'h10000000) begin
      errors++; $display("FAIL sb_lanes got wen=%b strb=%b wdata=%h addr=%h exp 1 0100 00ab0000 10000000",
                         obs_wen, obs_wstrb, obs_wdata, obs_addr);
    end
    checks++;
    if (obs_result !== 32'd0 || obs_err !== 1'b0) begin
      errors++; $display("FAIL sb_wb got %h err=%b exp 0 err=0", obs_result, obs_err);
    end
  endtask

  task automatic test_misaligned();
    do_txn(1'b1, 1'b0, 3'd2, 32'h00000006, 32'h0, 32'h0, 0, 0, 0, 1'b0);
    checks++;
    if (obs_saw_req !== 1'b0 || obs_lat !== 1 || obs_err !== 1'b1 || obs_result !== 32'd0) begin
      errors++; $display("FAIL misal_lw got req=%b lat=%0d err=%b res=%h exp 0 1 1 0",
                         obs_saw_req, obs_lat, obs_err, obs_result);
    end
    do_txn(1'b0, 1'b1, 3'd1, 32'h00000001, 32'h5555, 32'h0, 0, 0, 0, 1'b0);
    checks++;
    if (obs_saw_req !== 1'b0 || obs_lat !== 1 || obs_err !== 1'b1 || obs_result !== 32'd0) begin
      errors++; $display("FAIL misal_sh got req=%b lat=%0d err=%b res=%h exp 0 1 1 0",
                         obs_saw_req, obs_lat, obs_err, obs_result);
    end
  endtask

  task automatic test_backpressure();
    do_txn(1'b1, 1'b0, 3'd1, 32'h2000000A, 32'h0, 32'hC3A5_7F01, 4, 3, 2, 1'b1);
    checks++;
    if (obs_req_stable !== 1'b1 || obs_wb_stable !== 1'b1) begin
      errors++; $display("FAIL bp_stable got req_stable=%b wb_stable=%b exp 1 1", obs_req_stable, obs_wb_stable);
    end
    checks++;
    if (obs_nreq !== 1 || obs_ready_early !== 1'b0) begin
      errors++; $display("FAIL bp_handshake got nreq=%0d early_ready=%b exp 1 0", obs_nreq, obs_ready_early);
    end
    checks++;
    if (obs_result !== 32'hFFFFC3A5 || obs_lat !== 10) begin
      errors++; $display("FAIL bp_result got %h lat=%0d exp ffffc3a5 lat=10", obs_result, obs_lat);
    end
    checks++;
    if (ex_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b exp 1", ex_ready); end
  endtask

  task automatic test_passthru();
    do_txn(1'b0, 1'b0, 3'd3, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0, 0, 1'b0);
    checks++;
    if (obs_result !== 32'hDEADBEEF || obs_lat !== 1 || obs_saw_req !== 1'b0 || obs_err !== 1'b0) begin
      errors++; $display("FAIL passthru got res=%h lat=%0d req=%b err=%b exp deadbeef 1 0 0",
                         obs_result, obs_lat, obs_saw_req, obs_err);
    end
    mem_resp_valid = 1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_resp_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0 || mem_req_valid !== 1'b0 || ex_ready !== 1'b1) begin
      errors++; $display("FAIL spurious_resp got wbv=%b req=%b rdy=%b exp 0 0 1", wb_valid, mem_req_valid, ex_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      do_txn(1'b0, 1'b0, 3'd0, v, 32'h0, 32'h0, 0, 0, 0, 1'b0);
      checks++;
      if (obs_ready_at_accept !== 1'b1 || obs_result !== v || ex_ready !== 1'b1) begin
        errors++; $display("FAIL b2b[%0d] got acc_rdy=%b res=%h post_rdy=%b exp 1 %h 1",
                           i, obs_ready_at_accept, obs_result, ex_ready, v);
      end
    end
  endtask

  task automatic test_random();
    logic        ld, st, e_wen;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata, e_res, e_wdata;
    logic [3:0]  e_wstrb;
    logic [2:0]  legal_ld [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bit          e_err, e_bus;
    int          sel, rl, sl, wl;
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 9));
      ld = (sel < 5) || (sel == 9 && $urandom_range(0, 1) == 1);
      st = (sel >= 5 && sel < 9) || (sel == 9 && $urandom_range(0, 1) == 1);
      f3 = 3'($urandom_range(0, 7));
      if (sel < 4) f3 = legal_ld[$urandom_range(0, 4)];
      if (sel >= 5 && sel < 8) f3 = 3'($urandom_range(0, 2));
      addr = $urandom; wdata = $urandom; rdata = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      rl = int'($urandom_range(0, 3)); sl = int'($urandom_range(0, 3)); wl = int'($urandom_range(0, 2));
      ref_op(ld, st, f3, addr, wdata, rdata, e_err, e_bus, e_res, e_wdata, e_wstrb);
      e_wen = st;
      do_txn(ld, st, f3, addr, wdata, rdata, rl, sl, wl, 1'($urandom));
      checks++;
      if (obs_result !== e_res || obs_err !== e_err) begin
        errors++; $display("FAIL rand_wb[%0d] ld=%b st=%b f3=%0d addr=%h got %h err=%b exp %h err=%b",
                           i, ld, st, f3, addr, obs_result, obs_err, e_res, e_err);
      end
      checks++;
      if (obs_saw_req !== e_bus || obs_nreq !== (e_bus ? 1 : 0) ||
          obs_lat !== (e_bus ? 3 + rl + sl : 1)) begin
        errors++; $display("FAIL rand_flow[%0d] got req=%b nreq=%0d lat=%0d exp req=%b lat=%0d",
                           i, obs_saw_req, obs_nreq, obs_lat, e_bus, e_bus ? 3 + rl + sl : 1);
      end
      if (e_bus) begin
        checks++;
        if (obs_addr !== {addr[31:2], 2'b00} || obs_wen !== e_wen || obs_wstrb !== e_wstrb ||
            (st && obs_wdata !== e_wdata) || obs_req_stable !== 1'b1) begin
          errors++; $display("FAIL rand_bus[%0d] got addr=%h wen=%b strb=%b wdata=%h exp %h %b %b %h",
                             i, obs_addr, obs_wen, obs_wstrb, obs_wdata, {addr[31:2], 2'b00},
                             e_wen, e_wstrb, e_wdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_store_sb();
    test_misaligned();
    test_backpressure();
    test_passthru();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
